// File: rtl/spi_transaction_scheduler_if.sv
// spi_transaction_scheduler_if: requester handshakes and SPI controller register ports
interface spi_transaction_scheduler_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req_valid, req_ready, wr_valid, wr_ready, rd_valid, rd_ready, done;
  logic [NUM_REQ*16-1:0] req_len;
  logic [NUM_REQ*32-1:0] wr_data;
  logic [31:0] rd_data, spi_mem_write, spi_mem_read, spi_transaction_len;
  logic err, busy, spi_mem_write_strb, spi_mem_write_ptr_reset, spi_mem_read_strb, spi_mem_read_ptr_reset, spi_run;
  logic [2:0] spi_status;
  modport slave (
    input req_valid, req_len, wr_data, wr_valid, rd_ready, spi_mem_read, spi_status,
    output req_ready, wr_ready, rd_data, rd_valid, done, err, busy, spi_mem_write, spi_mem_write_strb,
      spi_mem_write_ptr_reset, spi_mem_read_strb, spi_mem_read_ptr_reset, spi_transaction_len, spi_run
  );
  modport master (
    output req_valid, req_len, wr_data, wr_valid, rd_ready, spi_mem_read, spi_status,
    input req_ready, wr_ready, rd_data, rd_valid, done, err, busy, spi_mem_write, spi_mem_write_strb,
      spi_mem_write_ptr_reset, spi_mem_read_strb, spi_mem_read_ptr_reset, spi_transaction_len, spi_run
  );
endinterface

// File: rtl/spi_transaction_scheduler.sv
// spi_transaction_scheduler: round-robin sharing of one SPI controller among NUM_REQ requesters
module spi_transaction_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int MEM_DEPTH = 64,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic axi_clk,
  input logic axi_reset,
  spi_transaction_scheduler_if.slave bus
);
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [3:0] {IDLE, WR_RST, LOAD, RUN, WAIT_BUSY, WAIT_DONE, RD_RST, SETTLE, UNLOAD, FINISH} state_t;
  state_t state, nxt;
  logic [GW-1:0] ptr, g, pick;
  logic [NUM_REQ-1:0] gmask;
  logic [15:0] len, sel_len;
  logic [16:0] nw, cnt, req_nw;
  logic [31:0] tmr;
  logic err_q, req_bad, wr_hs, rd_hs, last, tmo, unused;
  assign sel_len = bus.req_len[pick*16 +: 16];
  assign req_nw = (17'(sel_len) + 17'd31) >> 5;
  assign req_bad = sel_len == '0 || req_nw > 17'(MEM_DEPTH);
  assign gmask = NUM_REQ'(1) << g;
  assign wr_hs = state == LOAD && bus.wr_valid[g];
  assign rd_hs = state == UNLOAD && bus.rd_ready[g];
  assign last = cnt == nw - 17'd1;
  assign tmo = tmr == 32'(TIMEOUT_CYCLES - 1);
  assign unused = &{1'b0, bus.spi_status[2]};
  // first requesting index at or after the round-robin pointer; lowest offset wins
  always_comb begin
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req_valid[(int'(ptr) + k) % NUM_REQ]) pick = GW'((int'(ptr) + k) % NUM_REQ);
  end
  // state register plus the grant, length, word counter and shared wait/settle timer
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      len <= '0;
      nw <= '0;
      cnt <= '0;
      tmr <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && |bus.req_valid) begin
        g <= pick;
        len <= sel_len;
        nw <= req_nw;
        err_q <= req_bad;
      end
      if ((state == WAIT_BUSY || state == WAIT_DONE) && nxt == FINISH) err_q <= 1'b1;
      cnt <= (state == WR_RST || state == RD_RST) ? '0 : (wr_hs || rd_hs) ? cnt + 17'd1 : cnt;
      tmr <= (state == WAIT_BUSY || state == WAIT_DONE || state == SETTLE) ? tmr + 32'd1 : '0;
      if (state == FINISH) ptr <= int'(g) == NUM_REQ - 1 ? '0 : g + GW'(1);
    end
  end
  // next-state: the grant is fixed from IDLE until FINISH
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (|bus.req_valid) nxt = req_bad ? FINISH : WR_RST;
      WR_RST: nxt = LOAD;
      LOAD: if (wr_hs && last) nxt = RUN;
      RUN: nxt = WAIT_BUSY;
      WAIT_BUSY: nxt = (bus.spi_status[0] || bus.spi_status[1]) ? WAIT_DONE : tmo ? FINISH : WAIT_BUSY;
      WAIT_DONE: nxt = bus.spi_status[1:0] == 2'b10 ? RD_RST : tmo ? FINISH : WAIT_DONE;
      RD_RST: nxt = SETTLE;
      SETTLE: if (tmr + 32'd1 >= 32'(SETTLE_CYCLES)) nxt = UNLOAD;
      UNLOAD: if (rd_hs) nxt = last ? FINISH : SETTLE;
      FINISH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // outputs decoded from state; strobes coincide with the handshakes that cause them
  always_comb begin
    bus.req_ready = (state == IDLE && |bus.req_valid) ? NUM_REQ'(1) << pick : '0;
    bus.wr_ready = state == LOAD ? gmask : '0;
    bus.rd_valid = state == UNLOAD ? gmask : '0;
    bus.done = state == FINISH ? gmask : '0;
    bus.err = state == FINISH && err_q;
    bus.busy = state != IDLE;
    bus.rd_data = state == UNLOAD ? bus.spi_mem_read : '0;
    bus.spi_mem_write = wr_hs ? bus.wr_data[g*32 +: 32] : '0;
    bus.spi_mem_write_strb = wr_hs;
    bus.spi_mem_write_ptr_reset = state == WR_RST;
    bus.spi_mem_read_strb = rd_hs;
    bus.spi_mem_read_ptr_reset = state == RD_RST;
    bus.spi_transaction_len = (state inside {RUN, WAIT_BUSY, WAIT_DONE, RD_RST, SETTLE, UNLOAD}) ? 32'(len) : '0;
    bus.spi_run = state == RUN;
  end
endmodule
